// File: rtl/tt_um_req_arbiter_if.sv
// Pin bundle of the Tiny Tapeout user slot used by the request arbiter.
// The harness side drives the inputs; the arbiter drives the outputs.
interface tt_um_req_arbiter_if;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic       ena;

  modport master (
    output ui_in,
    output uio_in,
    output ena,
    input  uo_out,
    input  uio_out,
    input  uio_oe
  );

  modport slave (
    input  ui_in,
    input  uio_in,
    input  ena,
    output uo_out,
    output uio_out,
    output uio_oe
  );
endinterface

// File: rtl/tt_um_req_arbiter.sv
// Four-requester round-robin / fixed-priority arbiter with grant-hold timeout.
// Requests are synchronised, then an IDLE/GRANT/RELEASE FSM sequences ownership.
module tt_um_req_arbiter #(
  parameter int unsigned HOLD_MAX = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  tt_um_req_arbiter_if.slave   pins
);

  localparam int unsigned N_REQ  = 4;
  localparam int unsigned IDX_W  = 2;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned SYNC_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [SYNC_W-1:0]   sync1_q, sync2_q;
  logic                any_q;
  logic [N_REQ-1:0]    grant_q, grant_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [IDX_W-1:0]    last_q, last_d;
  logic [CNT_W-1:0]    hold_q, hold_d;
  logic                flag_q, flag_d;

  logic [N_REQ-1:0]    sreq;
  logic                smode;
  logic                sclr;
  logic [IDX_W-1:0]    win_idx;
  logic [IDX_W-1:0]    rr_idx;
  logic                hold_expired;
  logic                timeout_set;
  logic                unused_ok;

  assign sreq  = sync2_q[N_REQ-1:0];
  assign smode = sync2_q[4];
  assign sclr  = sync2_q[5];

  // Two-flop synchroniser; any_q tracks |sreq as a flop of its own
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      any_q   <= 1'b0;
    end else begin
      sync1_q <= pins.ui_in[SYNC_W-1:0];
      sync2_q <= sync1_q;
      any_q   <= |sync1_q[N_REQ-1:0];
    end
  end

  // Winner: fixed = lowest set bit; round-robin = first set bit after last owner
  always_comb begin
    win_idx = '0;
    rr_idx  = '0;
    if (smode) begin
      for (int i = N_REQ - 1; i >= 0; i--) begin
        if (sreq[i]) win_idx = IDX_W'(i);
      end
    end else begin
      for (int k = N_REQ; k >= 1; k--) begin
        rr_idx = last_q + IDX_W'(k);
        if (sreq[rr_idx]) win_idx = rr_idx;
      end
    end
  end

  assign hold_expired = (hold_q == CNT_W'(HOLD_MAX));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (|sreq) state_d = ST_GRANT;
      ST_GRANT:   if (!sreq[owner_q] || hold_expired) state_d = ST_RELEASE;
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Output / datapath next values; grant and counter drop on entry to RELEASE
  always_comb begin
    grant_d     = grant_q;
    owner_d     = owner_q;
    last_d      = last_q;
    hold_d      = hold_q;
    timeout_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|sreq) begin
          grant_d = N_REQ'(1) << win_idx;
          owner_d = win_idx;
          hold_d  = CNT_W'(1);
        end
      end
      ST_GRANT: begin
        if (!sreq[owner_q]) begin
          grant_d = '0;
          hold_d  = '0;
        end else if (hold_expired) begin
          grant_d     = '0;
          hold_d      = '0;
          timeout_set = 1'b1;
        end else begin
          hold_d = hold_q + CNT_W'(1);
        end
      end
      ST_RELEASE: begin
        grant_d = '0;
        hold_d  = '0;
        last_d  = owner_q;
      end
      default: begin
        grant_d = '0;
        hold_d  = '0;
      end
    endcase
    // A timeout in the same cycle as a clear request keeps the flag set
    if (timeout_set)  flag_d = 1'b1;
    else if (sclr)    flag_d = 1'b0;
    else              flag_d = flag_q;
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q <= '0;
      owner_q <= '0;
      last_q  <= IDX_W'(N_REQ - 1);
      hold_q  <= '0;
      flag_q  <= 1'b0;
    end else begin
      grant_q <= grant_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      flag_q  <= flag_d;
    end
  end

  assign pins.uo_out  = {flag_q, any_q, owner_q, grant_q};
  assign pins.uio_out = {4'b0000, hold_q};
  assign pins.uio_oe  = 8'h0F;

  assign unused_ok = &{1'b0, pins.ena, pins.uio_in, pins.ui_in[7:6]};

endmodule

// File: tb/tb_tt_um_req_arbiter.sv
// Scoreboard bench for tt_um_req_arbiter: stimulus queues cycle-tagged expected
// pin values, a negedge monitor pops and compares them when their cycle arrives.
module tb_tt_um_req_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tt_um_req_arbiter_if pins();

  tt_um_req_arbiter #(.HOLD_MAX(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pins  (pins)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned at;
    logic [7:0]  uo;
    logic [7:0]  uio;
    logic [127:0] name;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic void push_exp(int unsigned at, logic [7:0] uo, logic [7:0] uio,
                                   logic [127:0] name);
    exp_t e;
    e.at   = at;
    e.uo   = uo;
    e.uio  = uio;
    e.name = name;
    sb.push_back(e);
  endfunction

  // Monitor: compare every due entry; an entry whose cycle passed unseen is a failure
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at == cyc) begin
        n_checks++;
        if (pins.uo_out !== sb[i].uo || pins.uio_out !== sb[i].uio || pins.uio_oe !== 8'h0F) begin
          n_fail++;
          $display("FAIL %0s cyc=%0d got uo_out=%h uio_out=%h uio_oe=%h want uo_out=%h uio_out=%h uio_oe=0f",
                   sb[i].name, cyc, pins.uo_out, pins.uio_out, pins.uio_oe, sb[i].uo, sb[i].uio);
        end
        sb.delete(i);
      end else if (sb[i].at < cyc) begin
        n_checks++;
        n_fail++;
        $display("FAIL %0s never sampled (due cyc=%0d, now %0d)", sb[i].name, sb[i].at, cyc);
        sb.delete(i);
      end
    end
  end

  task automatic at_cycle(input int unsigned c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  int unsigned t0, tb0, tc;

  initial begin
    pins.ui_in  = 8'h00;
    pins.uio_in = 8'h00;
    pins.ena    = 1'b1;
    rst_n       = 1'b0;

    at_cycle(2);
    push_exp(cyc, 8'h00, 8'h00, "rst_hold");

    // Round-robin rotation, all four requesting, timeouts every 8 cycles
    at_cycle(3);
    t0 = cyc;
    rst_n = 1'b1;
    pins.ui_in = 8'h0F;
    push_exp(t0 + 2,  8'h40, 8'h00, "a_any_pre");
    push_exp(t0 + 3,  8'h41, 8'h01, "a_g0_rise");
    push_exp(t0 + 10, 8'h41, 8'h08, "a_g0_hold8");
    push_exp(t0 + 11, 8'hC0, 8'h00, "a_g0_tmo");
    push_exp(t0 + 12, 8'hC0, 8'h00, "a_gap2");
    push_exp(t0 + 13, 8'hD2, 8'h01, "a_g1");
    push_exp(t0 + 23, 8'hE4, 8'h01, "a_g2");
    push_exp(t0 + 33, 8'hF8, 8'h01, "a_g3");
    push_exp(t0 + 43, 8'hC1, 8'h01, "a_g0_wrap");

    // Asynchronous reset in the middle of a grant
    at_cycle(t0 + 45);
    rst_n = 1'b0;
    push_exp(cyc,     8'h00, 8'h00, "rst_mid");
    push_exp(cyc + 1, 8'h00, 8'h00, "rst_mid2");
    at_cycle(t0 + 47);
    rst_n = 1'b1;
    pins.ui_in = 8'h00;
    push_exp(cyc + 3, 8'h00, 8'h00, "idle_noreq");

    // Early release: req2 for three cycles
    at_cycle(t0 + 50);
    tb0 = cyc;
    pins.ui_in = 8'h04;
    push_exp(tb0 + 3, 8'h64, 8'h01, "b_cnt1");
    push_exp(tb0 + 4, 8'h64, 8'h02, "b_cnt2");
    push_exp(tb0 + 5, 8'h24, 8'h03, "b_cnt3");
    push_exp(tb0 + 6, 8'h20, 8'h00, "b_release");
    at_cycle(tb0 + 3);
    pins.ui_in = 8'h00;

    // Fixed priority with req1/req3, then back to round-robin mid-grant
    at_cycle(tb0 + 8);
    tc = cyc;
    pins.ui_in = 8'h1A;
    push_exp(tc + 3,  8'h52, 8'h01, "c_fix_g1");
    push_exp(tc + 10, 8'h52, 8'h08, "c_fix_hold8");
    push_exp(tc + 11, 8'hD0, 8'h00, "c_fix_tmo");
    push_exp(tc + 13, 8'hD2, 8'h01, "c_fix_again");
    push_exp(tc + 20, 8'hD2, 8'h08, "c_fix_hold8b");
    push_exp(tc + 21, 8'hD0, 8'h00, "c_fix_tmo2");
    push_exp(tc + 23, 8'hF8, 8'h01, "c_rr_g3");
    at_cycle(tc + 15);
    pins.ui_in = 8'h0A;

    // Flag clear pulse, then clear held through a new timeout
    push_exp(tc + 26, 8'hF8, 8'h04, "d_flag_pre");
    push_exp(tc + 27, 8'h78, 8'h05, "d_flag_clr");
    push_exp(tc + 30, 8'h78, 8'h08, "d_hold8");
    push_exp(tc + 31, 8'hF0, 8'h00, "d_set_wins");
    push_exp(tc + 32, 8'h70, 8'h00, "d_clr_after");
    push_exp(tc + 33, 8'h52, 8'h01, "d_rr_g1");
    at_cycle(tc + 24);
    pins.ui_in = 8'h2A;
    at_cycle(tc + 25);
    pins.ui_in = 8'h0A;
    at_cycle(tc + 28);
    pins.ui_in = 8'h2A;

    // Sole requester req3 re-granted after its own timeout
    push_exp(tc + 36, 8'h52, 8'h04, "e_g1_last");
    push_exp(tc + 37, 8'h50, 8'h00, "e_g1_drop");
    push_exp(tc + 39, 8'h78, 8'h01, "e_g3_rise");
    push_exp(tc + 46, 8'h78, 8'h08, "e_g3_hold8");
    push_exp(tc + 47, 8'hF0, 8'h00, "e_g3_tmo");
    push_exp(tc + 48, 8'hF0, 8'h00, "e_gap2");
    push_exp(tc + 49, 8'hF8, 8'h01, "e_g3_again");
    at_cycle(tc + 34);
    pins.ui_in = 8'h08;

    at_cycle(tc + 55);
    pins.ui_in = 8'h00;
    at_cycle(tc + 60);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
